// File: rtl/mc_control_pkg.sv
// mc_control_pkg
//   Shared definitions for the multi-cycle control unit: ALU control codes,
//   opcode/funct constants, datapath select codes and the state encoding.
//   The state encoding is also what appears on the state_o debug port.
package mc_control_pkg;

  localparam int OP_W    = 6;
  localparam int CTR_W   = 3;
  localparam int STATE_W = 4;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_XOR = 3'b011,
    ALU_SLT = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SUB = 3'b110
  } alu_ctr_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26;
  localparam logic [5:0] F_SLT = 6'h2A;

  // ALU operand A / B select codes
  localparam logic [1:0] SRC_A_PC   = 2'b00;
  localparam logic [1:0] SRC_A_RS   = 2'b01;
  localparam logic [1:0] SRC_A_RT   = 2'b10;
  localparam logic [1:0] SRC_B_RT   = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;
  localparam logic [1:0] SRC_B_BR   = 2'b11;

  // PC source select codes
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

endpackage

// File: rtl/mc_control_alu_dec.sv
// mc_control_alu_dec
//   Combinational R-type function decoder.
//   Ports:
//     funct    in   6  IR[5:0]
//     alu_ctr  out  3  ALU operation for this funct (ADD when unsupported)
//     valid    out  1  funct is one of the supported R-type operations
module mc_control_alu_dec
  import mc_control_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_ctr,
  output logic       valid
);

  always_comb begin
    alu_ctr = ALU_ADD;
    valid   = 1'b1;
    case (funct)
      F_ADD:   alu_ctr = ALU_ADD;
      F_SUB:   alu_ctr = ALU_SUB;
      F_AND:   alu_ctr = ALU_AND;
      F_OR:    alu_ctr = ALU_OR;
      F_XOR:   alu_ctr = ALU_XOR;
      F_SLT:   alu_ctr = ALU_SLT;
      F_SLL:   alu_ctr = ALU_SLL;
      default: valid   = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// mc_control
//   Multi-cycle control FSM driving the datapath and ALU. Outputs are a
//   function of the current state; ir_we/pc_we and the FETCH/MEM_RD/MEM_WR
//   exits are gated by mem_ready, beq's pc_we by the ALU zero flag.
//   Ports:
//     clk, rst_n             clock, asynchronous active-low reset
//     opcode, funct          instruction fields from the IR
//     zero                   ALU zero flag (used in BRANCH)
//     mem_ready              memory completes the current access this cycle
//     mem_rd, mem_wr, iord   memory request and address select
//     ir_we, pc_we, pc_src   IR / PC load and PC source select
//     reg_we, reg_dst        register file write and destination select
//     mem_to_reg             write-back source select
//     alu_src_a, alu_src_b   ALU operand selects
//     ext_op                 1 sign-extend, 0 zero-extend immediate
//     alu_ctr                ALU operation
//     illegal                one-cycle pulse on unsupported opcode/funct
//     state_o                current state (debug)
module mc_control
  import mc_control_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int CTR_W   = 3,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    opcode,
  input  logic [OP_W-1:0]    funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               iord,
  output logic               ir_we,
  output logic               pc_we,
  output logic [1:0]         pc_src,
  output logic               reg_we,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               ext_op,
  output logic [CTR_W-1:0]   alu_ctr,
  output logic               illegal,
  output logic [STATE_W-1:0] state_o
);

  state_e     state;
  state_e     state_nxt;
  logic [2:0] r_ctr;
  logic       r_valid;
  logic       op_known;
  logic       decode_bad;

  mc_control_alu_dec u_alu_dec (
    .funct   (funct[5:0]),
    .alu_ctr (r_ctr),
    .valid   (r_valid)
  );

  // Instruction legality, only acted upon while in DECODE.
  always_comb begin
    case (opcode[5:0])
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI, OP_J: op_known = 1'b1;
      default:                                               op_known = 1'b0;
    endcase
    decode_bad = !op_known || ((opcode[5:0] == OP_RTYPE) && !r_valid);
  end

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // Next-state logic. Memory states hold until mem_ready; unused codes
  // fall back to FETCH.
  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:  state_nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (decode_bad) state_nxt = S_FETCH;
        else begin
          case (opcode[5:0])
            OP_RTYPE:        state_nxt = S_EXEC_R;
            OP_LW, OP_SW:    state_nxt = S_MEM_ADDR;
            OP_BEQ:          state_nxt = S_BRANCH;
            OP_ADDI, OP_ORI: state_nxt = S_EXEC_I;
            OP_J:            state_nxt = S_JUMP;
            default:         state_nxt = S_FETCH;
          endcase
        end
      end
      S_EXEC_R:   state_nxt = S_WB_R;
      S_EXEC_I:   state_nxt = S_WB_I;
      S_MEM_ADDR: state_nxt = (opcode[5:0] == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_nxt = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   state_nxt = mem_ready ? S_FETCH : S_MEM_WR;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // Output decode. While rst_n is low everything is held at its idle value
  // so a memory request drops in the same cycle reset is asserted.
  always_comb begin
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_ALU;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RT;
    ext_op     = 1'b1;
    alu_ctr    = CTR_W'(ALU_ADD);
    illegal    = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          mem_rd    = 1'b1;
          alu_src_b = SRC_B_FOUR;
          ir_we     = mem_ready;
          pc_we     = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = SRC_B_BR;
          illegal   = decode_bad;
        end
        S_EXEC_R: begin
          // sll shifts rt by the shamt field carried in the immediate
          if (funct[5:0] == F_SLL) begin
            alu_src_a = SRC_A_RT;
            alu_src_b = SRC_B_IMM;
          end else begin
            alu_src_a = SRC_A_RS;
            alu_src_b = SRC_B_RT;
          end
          alu_ctr = CTR_W'(r_ctr);
        end
        S_WB_R: begin
          reg_we  = 1'b1;
          reg_dst = 1'b1;
        end
        S_EXEC_I: begin
          alu_src_a = SRC_A_RS;
          alu_src_b = SRC_B_IMM;
          if (opcode[5:0] == OP_ORI) begin
            alu_ctr = CTR_W'(ALU_OR);
            ext_op  = 1'b0;
          end
        end
        S_WB_I: reg_we = 1'b1;
        S_MEM_ADDR: begin
          alu_src_a = SRC_A_RS;
          alu_src_b = SRC_B_IMM;
        end
        S_MEM_RD: begin
          mem_rd = 1'b1;
          iord   = 1'b1;
        end
        S_MEM_WB: begin
          reg_we     = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WR: begin
          mem_wr = 1'b1;
          iord   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = SRC_A_RS;
          alu_src_b = SRC_B_RT;
          alu_ctr   = CTR_W'(ALU_SUB);
          pc_src    = PC_ALUOUT;
          pc_we     = zero;
        end
        S_JUMP: begin
          pc_we  = 1'b1;
          pc_src = PC_JUMP;
        end
        default: ;
      endcase
    end
  end

  assign state_o = STATE_W'(state);

endmodule
